// File: rtl/segment_display_scheduler_pkg.sv
// Shared definitions for the segment display scheduler: FSM state encoding,
// hex-to-segment lookup table and blank/digit-enable constants.
package segment_display_scheduler_pkg;

   // Scheduler FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   // Segment patterns for nibble values 0..F, bit order gfedcba, active high.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // All segments dark.
   localparam logic [7:0] SEG_BLANK = 8'h00;

   // Active-low digit enables: [0] drives the high-nibble digit, [1] the low-nibble digit.
   localparam logic [1:0] DIGIT_OFF = 2'b11;
   localparam logic [1:0] DIGIT_HI  = 2'b10;
   localparam logic [1:0] DIGIT_LO  = 2'b01;

endpackage

// File: rtl/segment_display_scheduler_hex_seg_decoder.sv
// Combinational nibble to seven-segment decoder (gfedcba, active high).
module hex_seg_decoder
   import segment_display_scheduler_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Straight table lookup; no state.
   always_comb begin
      seg = HEX_SEG[nibble];
   end

endmodule

// File: rtl/segment_display_scheduler.sv
// Segment display scheduler: round-robin shares a two-digit hex display
// between NUM_SRC requesters. Each grant latches the winner's byte and holds
// it on the display for HOLD_CYCLES cycles while the two digits are scanned.
//
// Optional build macro: SEG_BLANK_IDLE_EN
//   defined   -> display blanked in IDLE; low-digit dp lit during SHOW for odd grant index
//   undefined -> last captured value keeps scanning in IDLE; dp always off
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no grant; waiting for any Req bit
// ST_LATCH | one cycle; grant driven to winner, winner Data captured at exit
// ST_SHOW  | grant held for HOLD_CYCLES cycles, captured value displayed
module segment_display_scheduler
   import segment_display_scheduler_pkg::*;
#(
   parameter int NUM_SRC     = 4,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int SCAN_DIV    = 50_000
) (
   input  logic                   CLK,
   input  logic                   Reset,
   input  logic [NUM_SRC-1:0]     Req,
   input  logic [8*NUM_SRC-1:0]   Data,
   output logic [NUM_SRC-1:0]     Grant,
   output logic                   Busy,
   output logic [7:0]             Segment,
   output logic [1:0]             Digit_En
);

   localparam int IDX_W  = $clog2(NUM_SRC);
   localparam int HOLD_W = $clog2(HOLD_CYCLES);
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NUM_SRC - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [SCAN_W-1:0] SCAN_TOP  = SCAN_W'(SCAN_DIV - 1);

   state_t              state_q, state_d;
   logic [NUM_SRC-1:0]  grant_q, grant_d;
   logic                busy_q;
   logic [IDX_W-1:0]    win_q, win_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [7:0]          disp_q, disp_d;
   logic [SCAN_W-1:0]   scan_q, scan_d;
   logic                digit_lo_q, digit_lo_d;
   logic [7:0]          seg_q, seg_d;
   logic [1:0]          den_q, den_d;

   logic                rr_found;
   logic [IDX_W-1:0]    rr_idx;
   logic [IDX_W-1:0]    rr_cand;
   logic [7:0]          win_data;
   logic [3:0]          nibble;
   logic [6:0]          seg7;

   // Round-robin pick: first requester at or after last_q+1, wrapping.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      rr_cand  = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         rr_cand = IDX_W'((int'(last_q) + 1 + k) % NUM_SRC);
         if (!rr_found && Req[rr_cand]) begin
            rr_found = 1'b1;
            rr_idx   = rr_cand;
         end
      end
   end

   // Byte of the currently granted source, captured at the end of LATCH.
   always_comb begin
      win_data = 8'h00;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (win_q == IDX_W'(i)) begin
            win_data = Data[8*i +: 8];
         end
      end
   end

   // FSM next-state, grant issue, capture and dwell down-counter.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      win_d   = win_q;
      last_d  = last_q;
      hold_d  = hold_q;
      disp_d  = disp_q;
      case (state_q)
         ST_IDLE: begin
            grant_d = '0;
            if (rr_found) begin
               state_d = ST_LATCH;
               grant_d = NUM_SRC'(1) << rr_idx;
               win_d   = rr_idx;
               last_d  = rr_idx;
            end
         end
         ST_LATCH: begin
            disp_d  = win_data;
            hold_d  = HOLD_LOAD;
            state_d = ST_SHOW;
         end
         ST_SHOW: begin
            if (hold_q == '0) begin
               // Back-to-back requests go straight to LATCH, skipping IDLE.
               if (rr_found) begin
                  state_d = ST_LATCH;
                  grant_d = NUM_SRC'(1) << rr_idx;
                  win_d   = rr_idx;
                  last_d  = rr_idx;
               end else begin
                  state_d = ST_IDLE;
                  grant_d = '0;
               end
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Scan divider runs in every state; digit flips on each wrap.
   always_comb begin
      scan_d     = scan_q + 1'b1;
      digit_lo_d = digit_lo_q;
      if (scan_q == SCAN_TOP) begin
         scan_d     = '0;
         digit_lo_d = ~digit_lo_q;
      end
   end

   // Decode from next-cycle values so Segment/Digit_En track the registered
   // display contents and the new value appears right after LATCH.
   always_comb begin
      nibble = digit_lo_d ? disp_d[3:0] : disp_d[7:4];
   end

   hex_seg_decoder u_hex_seg_decoder (
      .nibble (nibble),
      .seg    (seg7)
   );

   // Output segment/enable selection including optional idle blanking and dp.
   always_comb begin
      seg_d = {1'b0, seg7};
      den_d = digit_lo_d ? DIGIT_LO : DIGIT_HI;
`ifdef SEG_BLANK_IDLE_EN
      if (state_d == ST_IDLE) begin
         seg_d = SEG_BLANK;
         den_d = DIGIT_OFF;
      end else if (state_d == ST_SHOW && win_d[0] && digit_lo_d) begin
         seg_d[7] = 1'b1;
      end
`endif
   end

   // FSM state register.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Grant, arbiter history, dwell counter and display register.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         grant_q <= '0;
         busy_q  <= 1'b0;
         win_q   <= '0;
         last_q  <= LAST_RST;
         hold_q  <= '0;
         disp_q  <= 8'h00;
      end else begin
         grant_q <= grant_d;
         busy_q  <= |grant_d;
         win_q   <= win_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         disp_q  <= disp_d;
      end
   end

   // Scan counter and active-digit flag.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         scan_q     <= '0;
         digit_lo_q <= 1'b0;
      end else begin
         scan_q     <= scan_d;
         digit_lo_q <= digit_lo_d;
      end
   end

   // Segment and digit enables registered together so they switch on one edge.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         seg_q <= SEG_BLANK;
         den_q <= DIGIT_OFF;
      end else begin
         seg_q <= seg_d;
         den_q <= den_d;
      end
   end

   assign Grant    = grant_q;
   assign Busy     = busy_q;
   assign Segment  = seg_q;
   assign Digit_En = den_q;

endmodule

// File: doc/segment_display_scheduler.md
SEGMENT_DISPLAY_SCHEDULER -- requirements
Module: segment_display_scheduler

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of requesters sharing the display (2..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 50_000_000, dwell time per grant in CLK cycles (>=2).
REQ-003 SHALL have parameter SCAN_DIV, default 50_000, CLK cycles per digit-scan slot (>=1).
REQ-004 SHALL have port CLK  input  1  single system clock, rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port Req  input  NUM_SRC  per-source display request, level.
REQ-007 SHALL have port Data  input  8*NUM_SRC  per-source 8-bit value; source i occupies bits [8i+7:8i].
REQ-008 SHALL have port Grant  output  NUM_SRC  one-hot grant, registered.
REQ-009 SHALL have port Busy  output  1  high while any grant is active.
REQ-010 SHALL have port Segment  output  8  active-high segments: [6:0]=gfedcba, [7]=dp.
REQ-011 SHALL have port Digit_En  output  2  active-low digit enables: [0]=high nibble digit, [1]=low nibble digit.

Function
REQ-012 SHALL implement FSM IDLE, LATCH, SHOW.
REQ-013 IDLE: Grant=0, Busy=0; if any Req bit is high, go to LATCH next cycle.
REQ-014 LATCH (1 cycle): Grant one-hot to the winner; the winner's Data is captured into an 8-bit display register at the end of the cycle.
REQ-015 SHALL select the winner round-robin: the first Req bit at or above (last_winner+1) mod NUM_SRC, wrapping; last_winner resets to NUM_SRC-1, so source 0 has first priority after reset.
REQ-016 SHOW: Grant held, Busy=1, for exactly HOLD_CYCLES cycles.
REQ-017 On the last SHOW cycle: go to LATCH if any Req bit is high, with no IDLE gap; otherwise go to IDLE.
REQ-018 Deassertion of Req or changes to Data during SHOW SHALL NOT alter the captured value or shorten the dwell.
REQ-019 Latency: if Req rises while in IDLE at cycle t, Grant SHALL assert at t+1 and the new value SHALL be displayed from t+2.
REQ-020 A scan counter SHALL count 0..SCAN_DIV-1 continuously in all states; at wrap, the active digit toggles.
REQ-021 Digit_En SHALL be 2'b10 while the high nibble is shown and 2'b01 while the low nibble is shown; it is never 2'b00.
REQ-022 Segment SHALL be the hex (0-F) encoding of the active nibble of the display register, with Segment and Digit_En registered together so they change on the same edge.
REQ-023 Segment[7] (dp) SHALL be 0 unless enabled by REQ-029.

Reset
REQ-024 On Reset low, all outputs SHALL clear asynchronously: Grant=0, Busy=0, Segment=8'h00, Digit_En=2'b11.
REQ-025 On Reset low, FSM=IDLE, display register=8'h00, scan counter=0 (high digit), last_winner=NUM_SRC-1.
REQ-026 Reset asserted during SHOW SHALL abort the dwell immediately, with no completion cycle.

Configuration
REQ-027 Macro SEG_BLANK_IDLE_EN.
REQ-028 With SEG_BLANK_IDLE_EN defined: in IDLE, Segment=8'h00 and Digit_En=2'b11; scanning continues internally.
REQ-029 With SEG_BLANK_IDLE_EN defined: during SHOW, the dp of the low digit SHALL be lit when the granted index is odd.
REQ-030 Without SEG_BLANK_IDLE_EN: in IDLE, the last captured value remains scanned, and dp is always 0.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration, the 16-entry hex-to-segment constant table, and the blank/digit-enable constants.
REQ-032 SHALL instantiate one sub-module, hex_seg_decoder (4-bit nibble to 7-bit segments, combinational).
REQ-033 SHALL contain no other sub-modules.
REQ-034 The round-robin arbiter SHALL stay inline.

Verification (HOLD_CYCLES=8, SCAN_DIV=2, NUM_SRC=4)
REQ-035 Reset low mid-SHOW with Grant=4'b0100 -> same cycle: Grant=0, Busy=0, Segment=0, Digit_En=2'b11.
REQ-036 Only Req[2] high, Data[2]=8'h3A, in IDLE at t -> Grant=4'b0100 at t+1; from t+2, Segment alternates 8'h4F ("3") with Digit_En=10 and 8'h77 ("A") with Digit_En=01, every 2 cycles; dwell lasts 8 cycles.
REQ-037 Req=4'b1111 held -> Grant sequence 0001, 0010, 0100, 1000, 0001, each 9 cycles (LATCH+8), with no IDLE gaps.
REQ-038 Req[1] pulsed for 1 cycle in IDLE, Data[1]=8'hF0 then changed to 8'h11 -> 8'hF0 displayed for the full dwell, then FSM returns to IDLE.
REQ-039 After the dwell of REQ-038: with SEG_BLANK_IDLE_EN defined, Digit_En=11 in IDLE; without it, "F0" keeps scanning.
REQ-040 Winner source 3 done, then Req=4'b1001 -> source 0 granted next (wrap-around).
